// File: rtl/psimd_pkg.sv
// Shared definitions for the packed-SIMD add/sub datapath: op encodings and
// saturation pattern helpers sized from the lane width.
package psimd_pkg;

    localparam logic [1:0] OP_ADD_SAT  = 2'b00;
    localparam logic [1:0] OP_SUB_SAT  = 2'b01;
    localparam logic [1:0] OP_ADD_WRAP = 2'b10;
    localparam logic [1:0] OP_SUB_WRAP = 2'b11;

    // Callers slice the low w bits: 0 followed by all 1s, and 1 followed by all 0s.
    function automatic logic [63:0] sat_max_pat(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_pat(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/psimd_lane.sv
// One two's-complement lane: modular add/sub plus signed overflow detection.
module psimd_lane #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic              sub,
    output logic [LANE_W-1:0] raw,
    output logic              ovf,
    output logic              sign_a
);

    logic [LANE_W-1:0] b_eff;

    assign b_eff  = sub ? ~b_i : b_i;
    assign raw    = a_i + b_eff + {{(LANE_W-1){1'b0}}, sub};
    assign sign_a = a_i[LANE_W-1];
    // Same-sign effective operands whose result flips sign covers both add and sub.
    assign ovf    = (a_i[LANE_W-1] == b_eff[LANE_W-1]) && (raw[LANE_W-1] != a_i[LANE_W-1]);

endmodule

// File: rtl/psimd_addsub.sv
// Two-stage packed-SIMD adder/subtractor with saturating/wrapping modes,
// per-lane overflow and sticky overflow flags behind a valid/ready handshake.
module psimd_addsub
    import psimd_pkg::*;
#(
    parameter  int LANE_W = 4,
    parameter  int LANES  = 4,
    localparam int DATA_W = LANE_W * LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic [LANES-1:0]  lane_ovf,
    output logic [LANES-1:0]  ovf_sticky,
    input  logic              sticky_clr
);

    localparam logic [LANE_W-1:0] SAT_MAX = LANE_W'(sat_max_pat(LANE_W));
    localparam logic [LANE_W-1:0] SAT_MIN = LANE_W'(sat_min_pat(LANE_W));

    logic              en;
    logic              sub;
    logic              wrap;
    logic [DATA_W-1:0] raw_c;
    logic [LANES-1:0]  ovf_c;
    logic [LANES-1:0]  sign_c;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_raw;
    logic [LANES-1:0]  s1_ovf;
    logic [LANES-1:0]  s1_sign;
    logic              s1_wrap;
    logic [DATA_W-1:0] sat_c;

    // A single enable stalls the whole pipe, so a held output never loses a beat.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign sub      = (op == OP_SUB_SAT) || (op == OP_SUB_WRAP);
    assign wrap     = (op == OP_ADD_WRAP) || (op == OP_SUB_WRAP);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        psimd_lane #(.LANE_W(LANE_W)) u_lane (
            .a_i    (a[i*LANE_W +: LANE_W]),
            .b_i    (b[i*LANE_W +: LANE_W]),
            .sub    (sub),
            .raw    (raw_c[i*LANE_W +: LANE_W]),
            .ovf    (ovf_c[i]),
            .sign_a (sign_c[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_ovf   <= '0;
            s1_sign  <= '0;
            s1_wrap  <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_raw  <= raw_c;
                s1_ovf  <= ovf_c;
                s1_sign <= sign_c;
                s1_wrap <= wrap;
            end
        end
    end

    always_comb begin
        sat_c = s1_raw;
        for (int i = 0; i < LANES; i++) begin
            if (s1_ovf[i] && !s1_wrap)
                sat_c[i*LANE_W +: LANE_W] = s1_sign[i] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            lane_ovf  <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum      <= sat_c;
                lane_ovf <= s1_ovf;
            end
        end
    end

    // Clear and set in the same cycle: the new overflow bits survive the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= '0;
        else if (sticky_clr)
            ovf_sticky <= (out_valid && out_ready) ? lane_ovf : '0;
        else if (out_valid && out_ready)
            ovf_sticky <= ovf_sticky | lane_ovf;
    end

endmodule
